fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline: owns the PC register, issues single-outstanding requests to instruction memory, and drives the IF/ID pipeline register. It sits directly upstream of the load-use hazard logic, which supplies `pc_write`/`ifid_write`, and of decode, which consumes `ifid_*`. It absorbs variable memory latency, load-use stalls and branch redirects from EX without losing or duplicating instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `XLEN`, default 32: address/instruction width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_write`  in  1  from hazard unit; 0 = hold PC.
- `ifid_write`  in  1  from hazard unit; 0 = hold IF/ID.
- `branch_taken`  in  1  redirect request from EX.
- `branch_target`  in  XLEN  redirect address, valid with `branch_taken`.
- `imem_req`  out  1  request strobe; memory always accepts.
- `imem_addr`  out  XLEN  request address, valid with `imem_req`.
- `imem_rvalid`  in  1  response strobe, ≥1 cycle after its request.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `ifid_pc`  out  XLEN  PC of instruction in IF/ID.
- `ifid_instr`  out  32  instruction in IF/ID.
- `ifid_valid`  out  1  IF/ID holds a real instruction.

## Operation
- `stall` = !(pc_write && ifid_write).
- States: FETCH (issue request), WAIT (one request outstanding), HOLD (response buffered in skid register, IF/ID stalled). Flag `kill` marks the outstanding response as wrong-path.
- FETCH: `imem_req`=1, `imem_addr`=pc → WAIT. Responses arriving in FETCH are ignored.
- WAIT, no `imem_rvalid`: IF/ID loads bubble (`ifid_valid`=0) unless `stall`.
- WAIT, `imem_rvalid`, `kill`=0, !stall: IF/ID ← {pc, rdata, valid=1}; pc ← pc+4; same cycle `imem_req`=1, `imem_addr`=pc+4; stay WAIT.
- WAIT, `imem_rvalid`, `kill`=0, stall: skid ← rdata → HOLD; PC and IF/ID hold.
- WAIT, `imem_rvalid`, `kill`=1: discard, clear `kill` → FETCH.
- HOLD, !stall: IF/ID ← {pc, skid, 1}; pc ← pc+4 → FETCH.
- `branch_taken` (priority over stall and over every case above): pc ← `branch_target`; `ifid_valid` ← 0. FETCH → WAIT with `kill`=1. WAIT without rvalid → `kill`=1. WAIT with rvalid → discard, `kill`=0, FETCH. HOLD → drop skid, FETCH. A second redirect while killed only updates pc.
- PC arithmetic is modulo 2^XLEN; pc+4 wraps from 32'hFFFF_FFFC to 0. `branch_target` is used unmodified; no alignment check.

## Timing
- Reset values: pc=`RESET_PC`, state=FETCH, `kill`=0, `ifid_valid`=0, `ifid_pc`=0, `ifid_instr`=32'h0000_0013 (NOP), skid=NOP. `imem_req` forced 0 while `rst`=1.
- First request goes out in the cycle after `rst` deasserts.
- `imem_req`/`imem_addr` are combinational from state, `imem_rvalid`, stall and `branch_taken`. All other outputs are registered.
- 1-cycle memory, no stalls: one instruction per cycle into IF/ID.
- Redirect: the request for the target leaves ≥1 cycle after `branch_taken`. The first target instruction appears in IF/ID one cycle after its response.
- `rst` mid-request returns to FETCH. Memory shares `rst`, so no stale response survives reset.

## Structure
- Shared `riscv_pkg` header: `NOP_INSTR`=32'h0000_0013, fetch state encodings (2-bit), XLEN default.
- Skid register and kill flag stay inline; no sub-module.

## Test plan
- Reset, 1-cycle memory returning rdata=addr: `ifid_pc` sequence 0,4,8,12 on consecutive cycles; `ifid_valid`=1 from the third cycle after reset release.
- 3-cycle memory latency: each instruction is followed by bubbles (`ifid_valid`=0). No address is requested twice.
- `pc_write`=`ifid_write`=0 for 2 cycles while a response arrives: HOLD entered. IF/ID is unchanged during the stall. After release the buffered instruction appears once; next `imem_addr` = pc+4.
- `branch_taken`, target 32'h100, while a request to 0x10 is outstanding: response for 0x10 is dropped. `ifid_valid`=0, next `imem_addr`=0x100, `ifid_pc`=0x100 follows.
- `branch_taken` in the same cycle as stall and as `imem_rvalid`: redirect wins. IF/ID is flushed and the response is discarded.
- PC 32'hFFFF_FFFC fetched: next `imem_addr`=0. `rst` asserted while in WAIT returns to `imem_addr`=`RESET_PC`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline: canonical NOP, default width
// and the instruction-fetch state encodings.
package riscv_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem requests,
// one-entry skid buffer for responses that land during a stall, IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            ifid_write,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic            ifid_valid
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_kill;
  logic [31:0]     r_skid;
  logic [XLEN-1:0] r_ifid_pc;
  logic [31:0]     r_ifid_instr;
  logic            r_ifid_valid;

  logic            w_stall;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_stall    = !(pc_write && ifid_write);
  assign w_pc_plus4 = r_pc + XLEN'(4);

  // A response accepted straight into IF/ID lets the next request leave in the same cycle.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_pc;
    if (!rst) begin
      case (r_state)
        ST_FETCH: imem_req = 1'b1;
        ST_WAIT: begin
          if (imem_rvalid && !r_kill && !w_stall && !branch_taken) begin
            imem_req  = 1'b1;
            imem_addr = w_pc_plus4;
          end
        end
        default: imem_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_skid       <= NOP_INSTR;
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (branch_taken) begin
      // A request already in flight must still be drained; kill marks it wrong-path.
      r_pc         <= branch_target;
      r_ifid_valid <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          r_state <= ST_WAIT;
          r_kill  <= 1'b1;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            r_kill  <= 1'b0;
            r_state <= ST_FETCH;
          end else begin
            r_kill  <= 1'b1;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end else begin
      case (r_state)
        ST_FETCH: begin
          r_state <= ST_WAIT;
          if (!w_stall) r_ifid_valid <= 1'b0;
        end
        ST_WAIT: begin
          if (imem_rvalid && r_kill) begin
            r_kill  <= 1'b0;
            r_state <= ST_FETCH;
            if (!w_stall) r_ifid_valid <= 1'b0;
          end else if (imem_rvalid && w_stall) begin
            r_skid  <= imem_rdata;
            r_state <= ST_HOLD;
          end else if (imem_rvalid) begin
            r_ifid_pc    <= r_pc;
            r_ifid_instr <= imem_rdata;
            r_ifid_valid <= 1'b1;
            r_pc         <= w_pc_plus4;
          end else if (!w_stall) begin
            r_ifid_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!w_stall) begin
            r_ifid_pc    <= r_pc;
            r_ifid_instr <= r_skid;
            r_ifid_valid <= 1'b1;
            r_pc         <= w_pc_plus4;
            r_state      <= ST_FETCH;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign ifid_pc    = r_ifid_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// latency/redirect/reset sequences, then randomized traffic against a stream model.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcWrite;
  logic        ifidWrite;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic [31:0] ifidPc;
  logic [31:0] ifidInstr;
  logic        ifidValid;

  int compared   = 0;
  int mismatched = 0;

  // Memory model: one pending request, response after memLat cycles.
  int          memLat = 1;
  logic        memPend = 1'b0;
  int          memCnt = 0;
  logic [31:0] memAddr = '0;

  // Stream model: next address expected on the bus and next PC expected in IF/ID.
  logic [31:0] expReqAddr;
  logic [31:0] expDeliv;
  logic [31:0] snapPc;
  logic [31:0] snapInstr;
  logic        snapValid;
  logic        prevStall;
  logic        prevBranch;
  int          sinceDeliv;
  int          deliveries;
  logic        seenReq;
  logic [31:0] seenAddr;

  typedef struct {
    logic        pw;
    logic        iw;
    logic        br;
    logic [31:0] tgt;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs[20];

  fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_write     (pcWrite),
    .ifid_write   (ifidWrite),
    .branch_taken (branchTaken),
    .branch_target(branchTarget),
    .imem_req     (imemReq),
    .imem_addr    (imemAddr),
    .imem_rvalid  (imemRvalid),
    .imem_rdata   (imemRdata),
    .ifid_pc      (ifidPc),
    .ifid_instr   (ifidInstr),
    .ifid_valid   (ifidValid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Instruction memory shares the reset, so nothing survives it.
  always @(posedge clk) begin
    if (rst) begin
      memPend <= 1'b0;
    end else begin
      if (memPend && memCnt != 0) memCnt <= memCnt - 1;
      else if (memPend) memPend <= 1'b0;
      if (imemReq) begin
        memPend <= 1'b1;
        memCnt  <= memLat - 1;
        memAddr <= imemAddr;
      end
    end
  end

  assign imemRvalid = memPend && (memCnt == 0);
  assign imemRdata  = imemRvalid ? memData(memAddr) : 32'h0;

  function automatic vec_t mk(input logic [2:0] ctl, input logic [31:0] tgt,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.pw = ctl[2]; v.iw = ctl[1]; v.br = ctl[0]; v.tgt = tgt;
    v.expReq = er; v.expAddr = ea; v.expValid = ev; v.expPc = ep;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Called at a falling edge: drives one cycle, checks the bus, then checks IF/ID after the edge.
  task automatic applyStimulus(input logic pw, input logic iw, input logic br,
                               input logic [31:0] tgt);
    rst          = 1'b0;
    pcWrite      = pw;
    ifidWrite    = iw;
    branchTaken  = br;
    branchTarget = tgt;
    #1;
    seenReq  = imemReq;
    seenAddr = imemAddr;
    if (imemReq) begin
      checkOutput("reqAddr", imemAddr, expReqAddr);
      checkOutput("singleOutstanding", 32'(memPend && !imemRvalid), 32'h0);
      expReqAddr = expReqAddr + 32'd4;
    end
    if (br) begin
      expReqAddr = tgt;
      expDeliv   = tgt;
      sinceDeliv = 0;
    end
    snapPc     = ifidPc;
    snapInstr  = ifidInstr;
    snapValid  = ifidValid;
    prevStall  = !(pw && iw);
    prevBranch = br;
    @(posedge clk);
    @(negedge clk);
    if (prevBranch) begin
      checkOutput("flushValid", 32'(ifidValid), 32'h0);
    end else if (prevStall) begin
      checkOutput("stallPc", ifidPc, snapPc);
      checkOutput("stallInstr", ifidInstr, snapInstr);
      checkOutput("stallValid", 32'(ifidValid), 32'(snapValid));
    end else if (ifidValid) begin
      checkOutput("delivPc", ifidPc, expDeliv);
      checkOutput("delivInstr", ifidInstr, memData(expDeliv));
      expDeliv   = expDeliv + 32'd4;
      sinceDeliv = 0;
      deliveries++;
    end else begin
      sinceDeliv++;
      if (sinceDeliv > 16) begin
        checkOutput("progress", 32'(sinceDeliv), 32'd0);
        sinceDeliv = 0;
      end
    end
  endtask

  task automatic doReset(input int lat);
    @(negedge clk);
    rst         = 1'b1;
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    branchTaken = 1'b0;
    branchTarget = '0;
    memLat      = lat;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reqInReset", 32'(imemReq), 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("resetValid", 32'(ifidValid), 32'h0);
    checkOutput("resetPc", ifidPc, 32'h0);
    checkOutput("resetInstr", ifidInstr, NOP_INSTR);
    expReqAddr = RESET_PC;
    expDeliv   = RESET_PC;
    sinceDeliv = 0;
  endtask

  initial begin
    int n;
    rst = 1'b1; pcWrite = 1'b1; ifidWrite = 1'b1;
    branchTaken = 1'b0; branchTarget = '0;
    deliveries = 0;

    // 1-cycle memory: streaming, a two-cycle stall, redirects and PC wrap.
    vecs[0]  = mk(3'b110, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0);
    vecs[1]  = mk(3'b110, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);
    vecs[2]  = mk(3'b110, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004);
    vecs[3]  = mk(3'b110, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008);
    vecs[4]  = mk(3'b110, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C);
    vecs[5]  = mk(3'b000, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_000C);
    vecs[6]  = mk(3'b100, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_000C);
    vecs[7]  = mk(3'b110, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0010);
    vecs[8]  = mk(3'b110, 32'h0,         1'b1, 32'h0000_0014, 1'b0, 32'h0);
    vecs[9]  = mk(3'b110, 32'h0,         1'b1, 32'h0000_0018, 1'b1, 32'h0000_0014);
    vecs[10] = mk(3'b111, 32'h100,       1'b0, 32'h0,         1'b0, 32'h0);
    vecs[11] = mk(3'b110, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h0);
    vecs[12] = mk(3'b110, 32'h0,         1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100);
    vecs[13] = mk(3'b001, 32'h200,       1'b0, 32'h0,         1'b0, 32'h0);
    vecs[14] = mk(3'b110, 32'h0,         1'b1, 32'h0000_0200, 1'b0, 32'h0);
    vecs[15] = mk(3'b110, 32'h0,         1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200);
    vecs[16] = mk(3'b111, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0, 32'h0);
    vecs[17] = mk(3'b110, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    vecs[18] = mk(3'b110, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC);
    vecs[19] = mk(3'b110, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);

    doReset(1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].pw, vecs[i].iw, vecs[i].br, vecs[i].tgt);
      checkOutput($sformatf("vec%0d.req", i), 32'(seenReq), 32'(vecs[i].expReq));
      if (vecs[i].expReq) checkOutput($sformatf("vec%0d.addr", i), seenAddr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d.valid", i), 32'(ifidValid), 32'(vecs[i].expValid));
      if (vecs[i].expValid) checkOutput($sformatf("vec%0d.pc", i), ifidPc, vecs[i].expPc);
    end

    // 3-cycle memory: one instruction every third cycle, bubbles in between.
    doReset(3);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      if (ifidValid) n++;
    end
    checkOutput("lat3Deliveries", 32'(n), 32'd3);

    // Redirect while the request for 0xC is still in flight.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
    checkOutput("killReq0", 32'(seenReq), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("killReq1", 32'(seenReq), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("killReq2", 32'(seenReq), 32'h0);
    checkOutput("killDropped", 32'(ifidValid), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("targetReq", 32'(seenReq), 32'h1);
    checkOutput("targetAddr", seenAddr, 32'h100);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("targetValid", 32'(ifidValid), 32'h1);
    checkOutput("targetPc", ifidPc, 32'h100);

    // Reset while a request is outstanding restarts from the reset PC.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    doReset(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("postResetReq", 32'(seenReq), 32'h1);
    checkOutput("postResetAddr", seenAddr, RESET_PC);

    // Randomized stalls, redirects and memory latency against the stream model.
    deliveries = 0;
    for (int seg = 0; seg < 3; seg++) begin
      doReset(int'($urandom_range(1, 4)));
      for (int c = 0; c < 400; c++) begin
        logic        pw, iw, br;
        logic [31:0] tgt;
        pw  = ($urandom_range(0, 99) >= 15);
        iw  = ($urandom_range(0, 99) >= 15);
        br  = ($urandom_range(0, 99) < 6);
        tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_FFFC);
        applyStimulus(pw, iw, br, tgt);
      end
    end
    checkOutput("randomProgress", 32'(deliveries > 100), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
